// File: rtl/regfile_reader_if.sv
// Register-file dump bus: request (start/base/count), read port, output stream, status.
// Latency: none (signal bundle only).
// Backpressure: out_ready from the sink stalls the stream; start is sampled only when idle.
//
// Ports: master = regfile_reader (drives rAddr, stream outputs and status),
//        slave  = environment (drives request, rData and out_ready).
interface regfile_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] sum;

    modport master (
        input  start, base, count, rData, out_ready,
        output rAddr, out_data, out_valid, out_last, busy, done, sum
    );

    modport slave (
        output start, base, count, rData, out_ready,
        input  rAddr, out_data, out_valid, out_last, busy, done, sum
    );
endinterface

// File: rtl/regfile_reader.sv
// Streams count words from a register file starting at base, keeping a running checksum.
// Latency: first word valid 2 edges after start; one word per 2 cycles with ready held high.
// Backpressure: out_data/out_valid/out_last held until out_ready; no read advances while stalled.
//
// Ports: clk, rst_n (async active-low); bus (regfile_reader_if.master) carries the request,
//        register-file read port, output stream, busy/done status and checksum.
module regfile_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr_q;      // doubles as the read address driven to the register file
    logic [ADDR_W:0]   remaining;   // one wider than the address so a full 64-word dump fits
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] sum_q;

    assign bus.rAddr     = addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.count != '0) begin
                            addr_q    <= bus.base;
                            remaining <= bus.count;
                            state     <= READ;
                        end else begin
                            // Empty dump: straight to completion, no word emitted.
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                READ: begin
                    out_data_q  <= bus.rData;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (remaining == REM_ONE);
                    state       <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        sum_q       <= sum_q + out_data_q;
                        remaining   <= remaining - REM_ONE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (remaining == REM_ONE) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;   // wraps naturally at 2^ADDR_W
                            state  <= READ;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: table of dumps with hand-computed checksums plus reset sequences.
// Latency: checks word n transfers on edge k+2+2n (plus any stall) after start at edge k.
// Backpressure: out_ready is dropped on a chosen word to exercise the stall path.
module tb_regfile_reader;
    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   count;
        int            pat;       // 0: mem[i]=i+1, 1: all ones
        int            stall_w;   // word index to stall on, -1 for none
        int            stall_n;   // cycles of out_ready low
        int            restart;   // pulse start mid-dump
        logic [DW-1:0] exp_sum;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] mem [64];

    always #5 clk = ~clk;

    regfile_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    regfile_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.rData = mem[bus.rAddr];

    int pass_cnt = 0;
    int total_cnt = 0;

    int nw, dones, done_t, busy_cyc, last_t, stall_cnt;
    bit timing_ok, stable_ok, have_prev;
    logic [DW-1:0] prev_data, prev_sum;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_dump(input int id, input vec_t v);
        logic [AW-1:0] a;
        int exp_t;
        for (int i = 0; i < 64; i++) mem[i] = (v.pat == 1) ? 32'hFFFF_FFFF : 32'(i + 1);
        nw = 0; dones = 0; done_t = -1; busy_cyc = 0; last_t = -1; stall_cnt = 0;
        timing_ok = 1'b1; stable_ok = 1'b1; have_prev = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.base = v.base; bus.count = v.count; bus.out_ready = 1'b1;
        @(negedge clk);
        // Scramble the request inputs; they must have no effect mid-dump.
        bus.base = 6'($urandom_range(0, 63));
        bus.count = 7'($urandom_range(0, 127));
        for (int t = 0; t < 400 && dones == 0 && nw <= 64; t++) begin
            bus.start = (t == 2 && v.restart != 0);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin dones++; done_t = t; end
            if (have_prev && (bus.out_data !== prev_data || bus.out_valid !== 1'b1 || bus.sum !== prev_sum))
                stable_ok = 1'b0;
            have_prev = 1'b0;
            if (bus.out_valid && nw == v.stall_w && stall_cnt < v.stall_n) begin
                bus.out_ready = 1'b0;
                stall_cnt++;
                have_prev = 1'b1;
                prev_data = bus.out_data;
                prev_sum = bus.sum;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                a = v.base + 6'(nw);
                chk($sformatf("v%0d_data%0d", id, nw), bus.out_data, mem[a]);
                chk($sformatf("v%0d_addr%0d", id, nw), 32'(bus.rAddr), 32'(a));
                chk($sformatf("v%0d_last%0d", id, nw), 32'(bus.out_last), 32'(nw == int'(v.count) - 1));
                exp_t = 1 + 2 * nw + ((v.stall_w >= 0 && nw >= v.stall_w) ? v.stall_n : 0);
                if (t != exp_t) timing_ok = 1'b0;
                last_t = t;
                nw++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk($sformatf("v%0d_done_pulses", id), 32'(dones), 32'd1);
        chk($sformatf("v%0d_words", id), 32'(nw), 32'(v.count));
        chk($sformatf("v%0d_sum", id), bus.sum, v.exp_sum);
        chk($sformatf("v%0d_busy_cycles", id), 32'(busy_cyc), 32'(2 * int'(v.count) + 1 + v.stall_n));
        chk($sformatf("v%0d_done_time", id), 32'(done_t), 32'((v.count == 0) ? 0 : last_t + 1));
        chk($sformatf("v%0d_timing", id), 32'(timing_ok), 32'd1);
        if (v.stall_n > 0) chk($sformatf("v%0d_stall_stable", id), 32'(stable_ok), 32'd1);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_sum_hold", id), bus.sum, v.exp_sum);
        chk($sformatf("v%0d_idle", id), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int seen;
        int rst_done;
        vecs[0] = '{base: 6'd0,  count: 7'd4,  pat: 0, stall_w: -1, stall_n: 0, restart: 0, exp_sum: 32'd10};
        vecs[1] = '{base: 6'd62, count: 7'd4,  pat: 0, stall_w: -1, stall_n: 0, restart: 0, exp_sum: 32'd130};
        vecs[2] = '{base: 6'd0,  count: 7'd4,  pat: 0, stall_w: 2,  stall_n: 5, restart: 0, exp_sum: 32'd10};
        vecs[3] = '{base: 6'd9,  count: 7'd0,  pat: 0, stall_w: -1, stall_n: 0, restart: 0, exp_sum: 32'd0};
        vecs[4] = '{base: 6'd0,  count: 7'd2,  pat: 1, stall_w: -1, stall_n: 0, restart: 1, exp_sum: 32'hFFFF_FFFE};
        vecs[5] = '{base: 6'd17, count: 7'd64, pat: 0, stall_w: -1, stall_n: 0, restart: 0, exp_sum: 32'd2080};
        vecs[6] = '{base: 6'd63, count: 7'd1,  pat: 0, stall_w: -1, stall_n: 0, restart: 0, exp_sum: 32'd64};

        bus.start = 1'b0; bus.base = '0; bus.count = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
        rst_n = 1'b0;
        #23;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", bus.sum, 32'd0);
        chk("rst_addr", 32'(bus.rAddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_dump(i, vecs[i]);

        // Reset during SEND of word 1 of a 4-word dump.
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
        @(negedge clk);
        bus.start = 1'b1; bus.base = 6'd0; bus.count = 7'd4; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !(seen == 1 && bus.out_valid); t++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        chk("mid_reached_word1", 32'(bus.out_data), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_sum", bus.sum, 32'd0);
        chk("mid_rst_addr", 32'(bus.rAddr), 32'd0);
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) rst_done++;
        end
        chk("mid_rst_no_done", 32'(rst_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // First edge after release must accept start; run_dump checks exact timing.
        run_dump(7, vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
